// File: rtl/bus_trace_pkg.sv
// Shared constants, FSM encoding and nibble formatter for the bus trace transmitter.
package bus_trace_pkg;

  localparam int unsigned REC_LEN = 9;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGuard
  } state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    return (n < 4'd10) ? (8'h30 + n8) : (8'h37 + n8);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with full/empty flags; caller must not push when full unless popping.
module trace_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (count_q == (AW + 1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/bus_trace_tx.sv
// Captures the 6502 bus on each mpu_clk fall and streams each capture as an ASCII hex
// record "AAAA DD\r\n" through the avr_interface byte handshake.
module bus_trace_tx
  import bus_trace_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mpu_clk,
  input  logic              trace_en,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic [DATA_W-1:0] data_bus,
  output logic [7:0]        tx_data,
  output logic              new_tx_data,
  input  logic              tx_busy,
  output logic              overflow,
  output logic [7:0]        drop_count,
  output logic              active
);

  localparam int unsigned REC_W = ADDR_W + DATA_W;

  logic             mpu_clk_q;
  logic             fall;
  logic             capture;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] fifo_rdata;
  logic [REC_W-1:0] rec_q;
  logic [ADDR_W-1:0] rec_addr;
  logic [DATA_W-1:0] rec_data;
  logic [7:0]       rec_char;
  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             overflow_q;
  logic [7:0]       drop_q;

  assign fall    = ~mpu_clk & mpu_clk_q;
  assign capture = fall & trace_en;
  assign pop     = (state_q == StIdle) & ~fifo_empty;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push    = capture & (~fifo_full | pop);
  assign drop    = capture & fifo_full & ~pop;

  trace_fifo #(
    .WIDTH (REC_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({addr_bus, data_bus}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rec_addr = rec_q[DATA_W +: ADDR_W];
  assign rec_data = rec_q[DATA_W-1:0];

  always_comb begin
    rec_char = ASCII_LF;
    case (idx_q)
      4'd0:    rec_char = hex_ascii(rec_addr[15:12]);
      4'd1:    rec_char = hex_ascii(rec_addr[11:8]);
      4'd2:    rec_char = hex_ascii(rec_addr[7:4]);
      4'd3:    rec_char = hex_ascii(rec_addr[3:0]);
      4'd4:    rec_char = ASCII_SP;
      4'd5:    rec_char = hex_ascii(rec_data[7:4]);
      4'd6:    rec_char = hex_ascii(rec_data[3:0]);
      4'd7:    rec_char = ASCII_CR;
      default: rec_char = ASCII_LF;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_data     = 8'h00;
    new_tx_data = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          idx_d   = 4'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tx_data     = rec_char;
          new_tx_data = 1'b1;
          state_d     = StGuard;
        end
      end
      StGuard: begin
        // Spans the cycle before the transmitter can raise tx_busy.
        if (idx_q == 4'(REC_LEN - 1)) begin
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mpu_clk_q  <= 1'b0;
      state_q    <= StIdle;
      idx_q      <= 4'd0;
      rec_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'h00;
    end else begin
      mpu_clk_q <= mpu_clk;
      state_q   <= state_d;
      idx_q     <= idx_d;
      if (pop) rec_q <= fifo_rdata;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign active     = (state_q != StIdle);

endmodule

// File: tb/tb_bus_trace_tx.sv
// Scoreboard bench for bus_trace_tx: expected bytes queued at capture, checked on each strobe.
module tb_bus_trace_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mpu_clk = 1'b0;
  logic        trace_en = 1'b1;
  logic [15:0] addr_bus = 16'h0000;
  logic [7:0]  data_bus = 8'h00;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        active;

  int         tests = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         strobe_cnt = 0;
  int         seen_cnt = 0;
  int         busy_cnt = 0;
  int         busy_len = 10;
  logic       hold_busy = 1'b0;
  logic       prev_strobe = 1'b0;
  int         s0;

  always #10 clk = ~clk;

  bus_trace_tx #(
    .FIFO_AW (2),
    .ADDR_W  (16),
    .DATA_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mpu_clk     (mpu_clk),
    .trace_en    (trace_en),
    .addr_bus    (addr_bus),
    .data_bus    (data_bus),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .active      (active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every strobed byte against the scoreboard head.
  always @(negedge clk) begin
    if (new_tx_data === 1'b1) begin
      check("strobe_spacing", {31'd0, prev_strobe}, 32'd0);
      check("active_on_strobe", {31'd0, active}, 32'd1);
      if (exp_q.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_byte: got %02h, expected no byte", tx_data);
      end else begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      strobe_cnt++;
    end
    prev_strobe = (new_tx_data === 1'b1);
  end

  // Transmitter model: busy for busy_len cycles after each strobe, or while held.
  always @(posedge clk) begin
    #1;
    if (strobe_cnt != seen_cnt) begin
      seen_cnt = strobe_cnt;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  task automatic push_record(input logic [15:0] a, input logic [7:0] d);
    string hx;
    hx = "0123456789ABCDEF";
    exp_q.push_back(hx[a[15:12]]);
    exp_q.push_back(hx[a[11:8]]);
    exp_q.push_back(hx[a[7:4]]);
    exp_q.push_back(hx[a[3:0]]);
    exp_q.push_back(8'h20);
    exp_q.push_back(hx[d[7:4]]);
    exp_q.push_back(hx[d[3:0]]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic mpu_fall(input logic [15:0] a, input logic [7:0] d, input bit expect_cap);
    @(negedge clk);
    mpu_clk = 1'b1;
    repeat (2) @(negedge clk);
    addr_bus = a;
    data_bus = d;
    mpu_clk  = 1'b0;
    if (expect_cap) push_record(a, d);
    @(negedge clk);
    addr_bus = ~a;
    data_bus = ~d;
  endtask

  task automatic wait_drain(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && active == 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_in_time", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_strobes(input int n, input int max_cycles);
    int  start;
    bit  done;
    start = strobe_cnt;
    done  = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #1;
      if (strobe_cnt - start >= n) begin
        done = 1'b1;
        break;
      end
    end
    check("strobes_in_time", {31'd0, done}, 32'd1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_new_tx_data", {31'd0, new_tx_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_count", {24'd0, drop_count}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single capture: 46 46 46 43 20 45 41 0D 0A
    s0 = strobe_cnt;
    mpu_fall(16'hFFFC, 8'hEA, 1'b1);
    wait_drain(500);
    check("single_byte_count", strobe_cnt - s0, 32'd9);
    check("single_overflow", {31'd0, overflow}, 32'd0);

    // Backpressure: nothing while held, first byte on the first free cycle
    hold_busy = 1'b1;
    @(negedge clk);
    s0 = strobe_cnt;
    mpu_fall(16'h1234, 8'h5A, 1'b1);
    repeat (200) @(negedge clk);
    check("hold_no_strobe", strobe_cnt - s0, 32'd0);
    check("hold_active", {31'd0, active}, 32'd1);
    hold_busy = 1'b0;
    @(negedge clk);
    #1;
    check("release_first_byte", strobe_cnt - s0, 32'd1);
    wait_drain(500);

    // Overflow: first capture is popped at once, four fill the FIFO, the sixth drops
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mpu_fall(16'(i), 8'(8'hC0 + i), i < 5);
    end
    @(negedge clk);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_drop_count", {24'd0, drop_count}, 32'd1);
    s0 = strobe_cnt;
    hold_busy = 1'b0;
    wait_drain(3000);
    check("ovf_byte_count", strobe_cnt - s0, 32'd45);
    check("ovf_flag_sticky", {31'd0, overflow}, 32'd1);

    // Enable gating
    trace_en = 1'b0;
    s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) mpu_fall(16'h7000 + 16'(i), 8'h11, 1'b0);
    repeat (20) @(negedge clk);
    check("gated_no_strobe", strobe_cnt - s0, 32'd0);
    trace_en = 1'b1;
    s0 = strobe_cnt;
    mpu_fall(16'hBEEF, 8'h42, 1'b1);
    wait_strobes(3, 200);
    trace_en = 1'b0;
    mpu_fall(16'hAAAA, 8'h55, 1'b0);
    wait_drain(500);
    check("gated_mid_count", strobe_cnt - s0, 32'd9);
    trace_en = 1'b1;

    // Edge selectivity: long high level, single capture on the fall
    s0 = strobe_cnt;
    @(negedge clk);
    addr_bus = 16'h5555;
    mpu_clk  = 1'b1;
    repeat (50) @(negedge clk);
    addr_bus = 16'h0C0F;
    data_bus = 8'h9D;
    mpu_clk  = 1'b0;
    push_record(16'h0C0F, 8'h9D);
    @(negedge clk);
    addr_bus = 16'h0000;
    wait_drain(500);
    check("edge_byte_count", strobe_cnt - s0, 32'd9);

    // Reset mid-record, with a second record waiting in the FIFO
    mpu_fall(16'h1357, 8'h24, 1'b1);
    mpu_fall(16'h2222, 8'h22, 1'b0);
    wait_strobes(4, 300);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    s0 = strobe_cnt;
    repeat (40) @(negedge clk);
    #1;
    check("rst_mid_no_strobe", strobe_cnt - s0, 32'd0);
    check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
    check("rst_mid_drop_count", {24'd0, drop_count}, 32'd0);
    check("rst_mid_active", {31'd0, active}, 32'd0);
    s0 = strobe_cnt;
    mpu_fall(16'hA0B1, 8'hF7, 1'b1);
    wait_drain(500);
    check("post_rst_byte_count", strobe_cnt - s0, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
